// File: rtl/fp_rffp_enc_pipe.sv
// FP -> RFFP streaming encoder: two-stage valid/ready pipeline with saturating
// range-loss counters. Stage 1 classifies the exponent, stage 2 packs the word.
module fp_rffp_enc_pipe #(
  parameter int EXP_WIDTH      = 8,
  parameter int MAN_WIDTH      = 7,
  parameter int RFFP_EXP       = 6,
  parameter int RFFP_MAN_WIDTH = 8,
  parameter int EXP_OFFSET     = 76,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]        in_fp,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [RFFP_EXP+RFFP_MAN_WIDTH:0]    out_rffp,
  output logic                                out_ovf,
  output logic                                out_unf,
  input  logic                                clr_cnt,
  output logic [CNT_WIDTH-1:0]                cnt_total,
  output logic [CNT_WIDTH-1:0]                cnt_ovf,
  output logic [CNT_WIDTH-1:0]                cnt_unf
);

  if (RFFP_MAN_WIDTH != MAN_WIDTH + 1) begin : g_bad_man_width
    $error("fp_rffp_enc_pipe: RFFP_MAN_WIDTH must equal MAN_WIDTH+1");
  end

  localparam int FP_W = 1 + EXP_WIDTH + MAN_WIDTH;

  // Exponent arithmetic is done one bit wider than E so EMAX fits unsigned.
  localparam logic [EXP_WIDTH:0] EMIN   = (EXP_WIDTH+1)'(EXP_OFFSET + 1);
  localparam logic [EXP_WIDTH:0] EMAX   = (EXP_WIDTH+1)'(EXP_OFFSET + 2**RFFP_EXP - 1);
  localparam logic [EXP_WIDTH:0] OFFSET = (EXP_WIDTH+1)'(EXP_OFFSET);

  typedef enum logic [1:0] {
    CLS_UNF  = 2'd0,
    CLS_NORM = 2'd1,
    CLS_OVF  = 2'd2
  } cls_e;

  // Handshake chain: each stage can load when it is empty or its consumer drains it.
  logic s1_valid_q, s2_valid_q;
  logic s1_take, s2_take, out_hs;

  assign s2_take  = !s2_valid_q || out_ready;
  assign s1_take  = !s1_valid_q || s2_take;
  assign in_ready = s1_take;
  assign out_hs   = s2_valid_q && out_ready;

  // Stage 1: classify exponent range and compute e_R.
  logic                 in_sign;
  logic [EXP_WIDTH:0]   in_exp;
  logic [MAN_WIDTH-1:0] in_frac;
  logic [RFFP_EXP-1:0]  s1_exp_d;
  cls_e                 s1_cls_d;

  assign in_sign  = in_fp[FP_W-1];
  assign in_exp   = {1'b0, in_fp[FP_W-2 -: EXP_WIDTH]};
  assign in_frac  = in_fp[MAN_WIDTH-1:0];
  assign s1_exp_d = RFFP_EXP'(in_exp - OFFSET);

  always_comb begin
    s1_cls_d = CLS_NORM;
    if (in_exp < EMIN)      s1_cls_d = CLS_UNF;
    else if (in_exp > EMAX) s1_cls_d = CLS_OVF;
  end

  logic                 s1_sign_q;
  cls_e                 s1_cls_q;
  logic [RFFP_EXP-1:0]  s1_exp_q;
  logic [MAN_WIDTH-1:0] s1_frac_q;

  // NOTE: sequential state uses non-blocking assignments only; the datapath
  // registers are reset too so the output word is a clean zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_cls_q   <= CLS_UNF;
      s1_exp_q   <= '0;
      s1_frac_q  <= '0;
    end else if (s1_take) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= in_sign;
        s1_cls_q  <= s1_cls_d;
        s1_exp_q  <= s1_exp_d;
        s1_frac_q <= in_frac;
      end
    end
  end

  // Stage 2: pack the RFFP word and sideband flags.
  logic [RFFP_EXP+RFFP_MAN_WIDTH:0] word_d;
  logic                             ovf_d, unf_d;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    word_d = {s1_sign_q, {(RFFP_EXP+RFFP_MAN_WIDTH){1'b0}}};
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    case (s1_cls_q)
      CLS_NORM: word_d = {s1_sign_q, s1_exp_q, 1'b1, s1_frac_q};
      CLS_OVF: begin
        word_d = {s1_sign_q, {(RFFP_EXP+RFFP_MAN_WIDTH){1'b1}}};
        ovf_d  = 1'b1;
      end
      default: unf_d = 1'b1;
    endcase
  end

  logic [RFFP_EXP+RFFP_MAN_WIDTH:0] word_q;
  logic                             ovf_q, unf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      word_q     <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else if (s2_take) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        word_q <= word_d;
        ovf_q  <= ovf_d;
        unf_q  <= unf_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_rffp  = word_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;

  // Profiling counters: count delivered words only; clear wins over a handshake.
  logic [CNT_WIDTH-1:0] total_q, ovf_cnt_q, unf_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q   <= '0;
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else if (clr_cnt) begin
      total_q   <= '0;
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else if (out_hs) begin
      if (total_q != '1)            total_q   <= total_q + 1'b1;
      if (ovf_q && ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 1'b1;
      if (unf_q && unf_cnt_q != '1) unf_cnt_q <= unf_cnt_q + 1'b1;
    end
  end

  assign cnt_total = total_q;
  assign cnt_ovf   = ovf_cnt_q;
  assign cnt_unf   = unf_cnt_q;

endmodule
